// File: rtl/countdown_timer.sv
// Loadable down-counter: start value arrives over a valid/ready handshake, counts down by G_STEP
// and pulses terminal when it reaches G_COUNT_TO, then either stops or reloads.
module countdown_timer #(
  parameter int G_DATA_WIDTH  = 8,
  parameter int G_COUNT_FROM  = 2 ** (G_DATA_WIDTH - 1),
  parameter int G_COUNT_TO    = 0,
  parameter int G_STEP        = 1,
  parameter bit G_AUTO_RELOAD = 1'b0
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    count_enable,
  input  logic                    load_valid,
  input  logic [G_DATA_WIDTH-1:0] load_value,
  output logic                    load_ready,
  output logic [G_DATA_WIDTH-1:0] count,
  output logic                    terminal,
  output logic                    busy
);

  localparam int W = G_DATA_WIDTH;
  localparam logic [W-1:0] COUNT_FROM_V = W'(G_COUNT_FROM);
  localparam logic [W-1:0] COUNT_TO_V   = W'(G_COUNT_TO);
  localparam logic [W-1:0] STEP_V       = W'(G_STEP);
  // One extra bit so COUNT_TO + STEP cannot wrap for values near the top of the range.
  localparam logic [W:0]   TERM_THRESH  = (W + 1)'(G_COUNT_TO + G_STEP);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t         state_reg,    state_next;
  logic [W-1:0]   count_reg,    count_next;
  logic [W-1:0]   reload_reg,   reload_next;
  logic           terminal_reg, terminal_next;
  logic           busy_reg,     busy_next;
  logic           pending_reg,  pending_next;
  logic           at_terminal;

  assign at_terminal = ({1'b0, count_reg} <= TERM_THRESH);

  always_comb begin
    state_next    = state_reg;
    count_next    = count_reg;
    reload_next   = reload_reg;
    terminal_next = 1'b0;
    pending_next  = pending_reg;
    case (state_reg)
      ST_IDLE, ST_DONE: begin
        if (load_valid) begin
          count_next   = load_value;
          reload_next  = load_value;
          pending_next = 1'b0;
          state_next   = ST_RUN;
        end
      end
      ST_RUN: begin
        if (count_enable) begin
          // In auto-reload the edge after a terminal pulse restores the start value silently.
          if (G_AUTO_RELOAD && pending_reg && (count_reg == COUNT_TO_V)) begin
            count_next   = reload_reg;
            pending_next = 1'b0;
          end else if (at_terminal) begin
            count_next    = COUNT_TO_V;
            terminal_next = 1'b1;
            if (G_AUTO_RELOAD) begin
              pending_next = 1'b1;
            end else begin
              state_next = ST_DONE;
            end
          end else begin
            count_next = count_reg - STEP_V;
          end
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
    busy_next = (state_next == ST_RUN);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg    <= ST_IDLE;
      count_reg    <= COUNT_FROM_V;
      reload_reg   <= COUNT_FROM_V;
      terminal_reg <= 1'b0;
      busy_reg     <= 1'b0;
      pending_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      count_reg    <= count_next;
      reload_reg   <= reload_next;
      terminal_reg <= terminal_next;
      busy_reg     <= busy_next;
      pending_reg  <= pending_next;
    end
  end

  assign load_ready = (state_reg != ST_RUN);
  assign count      = count_reg;
  assign terminal   = terminal_reg;
  assign busy       = busy_reg;

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench: three timer instances (defaults, step of 3, auto-reload) with hand-computed
// count/terminal/busy/load_ready expectations after each edge.
module tb_countdown_timer;

  logic       clock;
  logic       reset_n;
  logic       en [3];
  logic       lv [3];
  logic [7:0] val [3];
  logic       rdy [3];
  logic [7:0] cnt [3];
  logic       term [3];
  logic       bsy [3];

  int tests_run    = 0;
  int tests_failed = 0;

  countdown_timer u_def (
    .clock(clock), .reset_n(reset_n), .count_enable(en[0]), .load_valid(lv[0]),
    .load_value(val[0]), .load_ready(rdy[0]), .count(cnt[0]), .terminal(term[0]), .busy(bsy[0])
  );

  countdown_timer #(.G_STEP(3)) u_step (
    .clock(clock), .reset_n(reset_n), .count_enable(en[1]), .load_valid(lv[1]),
    .load_value(val[1]), .load_ready(rdy[1]), .count(cnt[1]), .terminal(term[1]), .busy(bsy[1])
  );

  countdown_timer #(.G_AUTO_RELOAD(1'b1)) u_ar (
    .clock(clock), .reset_n(reset_n), .count_enable(en[2]), .load_valid(lv[2]),
    .load_value(val[2]), .load_ready(rdy[2]), .count(cnt[2]), .terminal(term[2]), .busy(bsy[2])
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check_state(input int d, input string tag, input int exp_count,
                             input bit exp_term, input bit exp_busy);
    check_eq({tag, "_count"}, 32'(cnt[d]), 32'(exp_count));
    check_eq({tag, "_terminal"}, 32'(term[d]), 32'(exp_term));
    check_eq({tag, "_busy"}, 32'(bsy[d]), 32'(exp_busy));
    check_eq({tag, "_load_ready"}, 32'(rdy[d]), 32'(!exp_busy));
  endtask

  task automatic do_load(input int d, input logic [7:0] v);
    lv[d]  = 1'b1;
    val[d] = v;
    tick();
    lv[d]  = 1'b0;
    $display("[TB] load dut%0d value=%0d count=%0d busy=%0d", d, v, cnt[d], bsy[d]);
  endtask

  int gap_en   [5] = '{1, 0, 0, 1, 1};
  int gap_cnt  [5] = '{2, 2, 2, 1, 0};
  int gap_term [5] = '{0, 0, 0, 0, 1};
  int ar_cnt   [6] = '{1, 0, 2, 1, 0, 2};
  int ar_term  [6] = '{0, 1, 0, 0, 1, 0};

  initial begin
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      en[i]  = 1'b0;
      lv[i]  = 1'b0;
      val[i] = 8'd0;
    end

    // Asynchronous reset: values must appear before any clock edge.
    #2 reset_n = 1'b0;
    #1;
    check_state(0, "rst_async_def", 128, 1'b0, 1'b0);
    check_state(1, "rst_async_step", 128, 1'b0, 1'b0);
    check_state(2, "rst_async_ar", 128, 1'b0, 1'b0);
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    check_state(0, "idle_def", 128, 1'b0, 1'b0);

    // Basic countdown from 5.
    do_load(0, 8'd5);
    check_state(0, "basic_load", 5, 1'b0, 1'b1);
    en[0] = 1'b1;
    for (int c = 4; c >= 1; c--) begin
      tick();
      check_state(0, $sformatf("basic_c%0d", c), c, 1'b0, 1'b1);
    end
    tick();
    check_state(0, "basic_term", 0, 1'b1, 1'b0);
    tick();
    check_state(0, "basic_done", 0, 1'b0, 1'b0);
    tick();
    check_state(0, "basic_hold", 0, 1'b0, 1'b0);

    // Enable gaps; enable on the load edge itself must be ignored.
    do_load(0, 8'd3);
    check_state(0, "gap_load", 3, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      en[0] = gap_en[i][0];
      tick();
      check_state(0, $sformatf("gap_%0d", i), gap_cnt[i], gap_term[i][0], (i < 4));
    end
    en[0] = 1'b0;

    // Load of the terminal value: first enabled edge pulses terminal.
    do_load(0, 8'd0);
    check_state(0, "zero_load", 0, 1'b0, 1'b1);
    en[0] = 1'b1;
    tick();
    check_state(0, "zero_term", 0, 1'b1, 1'b0);
    tick();
    check_state(0, "zero_after", 0, 1'b0, 1'b0);
    en[0] = 1'b0;

    // Step of 3: 10,7,4,1,0 without wrapping.
    do_load(1, 8'd10);
    check_state(1, "step_load", 10, 1'b0, 1'b1);
    en[1] = 1'b1;
    tick();
    check_state(1, "step_7", 7, 1'b0, 1'b1);
    tick();
    check_state(1, "step_4", 4, 1'b0, 1'b1);
    tick();
    check_state(1, "step_1", 1, 1'b0, 1'b1);
    tick();
    check_state(1, "step_term", 0, 1'b1, 1'b0);
    tick();
    check_state(1, "step_hold", 0, 1'b0, 1'b0);
    en[1] = 1'b0;

    // Auto-reload with a load attempt while running.
    do_load(2, 8'd2);
    check_state(2, "ar_load", 2, 1'b0, 1'b1);
    en[2]  = 1'b1;
    lv[2]  = 1'b1;
    val[2] = 8'd7;
    for (int i = 0; i < 6; i++) begin
      tick();
      check_state(2, $sformatf("ar_%0d", i), ar_cnt[i], ar_term[i][0], 1'b1);
    end
    lv[2] = 1'b0;
    en[2] = 1'b0;

    // Reset while running at count 3.
    do_load(0, 8'd5);
    en[0] = 1'b1;
    tick();
    tick();
    check_state(0, "pre_rst", 3, 1'b0, 1'b1);
    #3 reset_n = 1'b0;
    #1;
    check_state(0, "rst_mid", 128, 1'b0, 1'b0);
    tick();
    check_state(0, "rst_mid_held", 128, 1'b0, 1'b0);
    reset_n = 1'b1;
    en[0]   = 1'b0;
    tick();
    check_state(0, "rst_released", 128, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
